// File: rtl/mem_bus_ctrl_pkg.sv
// Shared definitions for the memory bus controller: bus widths and FSM state encoding.
package mem_bus_ctrl_pkg;

    // Highest bit index of the processor data and word-address buses.
    localparam int DATA_INDEX_LIMIT    = 31;
    localparam int ADDRESS_INDEX_LIMIT = 25;

    // Controller states; the encodings match the existing project definitions.
    typedef enum logic [1:0] {
        MBC_IDLE   = 2'b00,
        MBC_ACCESS = 2'b01,
        MBC_DONE   = 2'b10
    } mbc_state_e;

    // A read and a write rising on the same clock cannot be serviced as one access.
    function automatic logic is_illegal_req(input logic rd_edge, input logic wr_edge);
        return rd_edge & wr_edge;
    endfunction

endpackage

// File: rtl/mem_bus_timer.sv
// Wait-state counter for one memory access: cleared at acceptance, counts
// ACCESS cycles without an acknowledge, flags the last permitted cycle.
module mem_bus_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic CLK,
    input  logic RST,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] count_reg;

    // Count wait cycles; the counter saturates instead of wrapping.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable && (count_reg != {CNT_W{1'b1}})) begin
            count_reg <= count_reg + CNT_W'(1);
        end
    end

    // The access is aborted on the edge where TIMEOUT-1 wait cycles have already elapsed.
    always_comb begin
        expire = (count_reg == CNT_W'(TIMEOUT - 1));
    end

endmodule

// File: rtl/mem_bus_ctrl.sv
// Memory bus controller: converts level READ/WRITE requests from the control
// unit into a single strobed memory access each, with a wait-state timeout.
module mem_bus_ctrl
    import mem_bus_ctrl_pkg::*;
#(
    parameter int DATA_W  = DATA_INDEX_LIMIT + 1,
    parameter int ADDR_W  = ADDRESS_INDEX_LIMIT + 1,
    parameter int TIMEOUT = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              REQ_READ,
    input  logic              REQ_WRITE,
    input  logic [ADDR_W-1:0] REQ_ADDR,
    input  logic [DATA_W-1:0] REQ_WDATA,
    output logic [DATA_W-1:0] RDATA,
    output logic              BUSY,
    output logic              DONE,
    output logic              ERR,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [DATA_W-1:0] MEM_WDATA,
    output logic              MEM_READ,
    output logic              MEM_WRITE,
    input  logic [DATA_W-1:0] MEM_RDATA,
    input  logic              MEM_ACK
);

    mbc_state_e        state_reg,     state_next;
    logic              prev_rd_reg,   prev_wr_reg;
    logic [DATA_W-1:0] rdata_reg,     rdata_next;
    logic [ADDR_W-1:0] mem_addr_reg,  mem_addr_next;
    logic [DATA_W-1:0] mem_wdata_reg, mem_wdata_next;
    logic              mem_read_reg,  mem_read_next;
    logic              mem_write_reg, mem_write_next;
    logic              busy_reg,      busy_next;
    logic              done_reg,      done_next;
    logic              err_reg,       err_next;

    logic              rd_edge, wr_edge;
    logic              tmr_clear, tmr_enable, tmr_expire;

    mem_bus_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .CLK    (CLK),
        .RST    (RST),
        .clear  (tmr_clear),
        .enable (tmr_enable),
        .expire (tmr_expire)
    );

    // Rising-edge detection; history cleared by reset so a request already
    // high when reset releases is seen as new.
    always_comb begin
        rd_edge = REQ_READ  & ~prev_rd_reg;
        wr_edge = REQ_WRITE & ~prev_wr_reg;
    end

    // Request history is tracked every cycle regardless of state, so a level
    // held through an access never re-triggers.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            prev_rd_reg <= 1'b0;
            prev_wr_reg <= 1'b0;
        end else begin
            prev_rd_reg <= REQ_READ;
            prev_wr_reg <= REQ_WRITE;
        end
    end

    // Next-state and next-output logic; every output is registered from these values.
    always_comb begin
        state_next     = state_reg;
        rdata_next     = rdata_reg;
        mem_addr_next  = mem_addr_reg;
        mem_wdata_next = mem_wdata_reg;
        mem_read_next  = mem_read_reg;
        mem_write_next = mem_write_reg;
        done_next      = 1'b0;
        err_next       = 1'b0;
        tmr_clear      = 1'b0;
        tmr_enable     = 1'b0;

        unique case (state_reg)
            MBC_IDLE: begin
                if (is_illegal_req(rd_edge, wr_edge)) begin
                    state_next = MBC_DONE;
                    done_next  = 1'b1;
                    err_next   = 1'b1;
                end else if (rd_edge) begin
                    state_next    = MBC_ACCESS;
                    mem_addr_next = REQ_ADDR;
                    mem_read_next = 1'b1;
                    tmr_clear     = 1'b1;
                end else if (wr_edge) begin
                    state_next     = MBC_ACCESS;
                    mem_addr_next  = REQ_ADDR;
                    mem_wdata_next = REQ_WDATA;
                    mem_write_next = 1'b1;
                    tmr_clear      = 1'b1;
                end
            end
            MBC_ACCESS: begin
                // An acknowledge on the final permitted cycle still counts as success.
                if (MEM_ACK) begin
                    if (mem_read_reg) begin
                        rdata_next = MEM_RDATA;
                    end
                    mem_read_next  = 1'b0;
                    mem_write_next = 1'b0;
                    done_next      = 1'b1;
                    state_next     = MBC_DONE;
                end else if (tmr_expire) begin
                    mem_read_next  = 1'b0;
                    mem_write_next = 1'b0;
                    done_next      = 1'b1;
                    err_next       = 1'b1;
                    state_next     = MBC_DONE;
                end else begin
                    tmr_enable = 1'b1;
                end
            end
            MBC_DONE: begin
                state_next = MBC_IDLE;
            end
            default: begin
                state_next     = MBC_IDLE;
                mem_read_next  = 1'b0;
                mem_write_next = 1'b0;
            end
        endcase

        busy_next = (state_next != MBC_IDLE);
    end

    // State and output registers; reset abandons any access without a DONE pulse.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_reg     <= MBC_IDLE;
            rdata_reg     <= '0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            mem_read_reg  <= 1'b0;
            mem_write_reg <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            rdata_reg     <= rdata_next;
            mem_addr_reg  <= mem_addr_next;
            mem_wdata_reg <= mem_wdata_next;
            mem_read_reg  <= mem_read_next;
            mem_write_reg <= mem_write_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
            err_reg       <= err_next;
        end
    end

    // Drive ports straight from their registers.
    always_comb begin
        RDATA     = rdata_reg;
        BUSY      = busy_reg;
        DONE      = done_reg;
        ERR       = err_reg;
        MEM_ADDR  = mem_addr_reg;
        MEM_WDATA = mem_wdata_reg;
        MEM_READ  = mem_read_reg;
        MEM_WRITE = mem_write_reg;
    end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Self-checking bench for mem_bus_ctrl: directed scenarios followed by random
// accesses, checked against a transaction-level model of the bus behaviour.
module tb_mem_bus_ctrl;

    localparam int DW = 32;
    localparam int AW = 26;
    localparam int TO = 16;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          REQ_READ = 1'b0;
    logic          REQ_WRITE = 1'b0;
    logic [AW-1:0] REQ_ADDR = '0;
    logic [DW-1:0] REQ_WDATA = '0;
    logic [DW-1:0] RDATA;
    logic          BUSY, DONE, ERR;
    logic [AW-1:0] MEM_ADDR;
    logic [DW-1:0] MEM_WDATA;
    logic          MEM_READ, MEM_WRITE;
    logic [DW-1:0] MEM_RDATA = '0;
    logic          MEM_ACK = 1'b0;

    int checks = 0;
    int errors = 0;

    // Model of the externally visible held values.
    logic [AW-1:0] m_addr  = '0;
    logic [DW-1:0] m_wdata = '0;
    logic [DW-1:0] m_rdata = '0;

    mem_bus_ctrl #(
        .DATA_W  (DW),
        .ADDR_W  (AW),
        .TIMEOUT (TO)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .REQ_READ  (REQ_READ),
        .REQ_WRITE (REQ_WRITE),
        .REQ_ADDR  (REQ_ADDR),
        .REQ_WDATA (REQ_WDATA),
        .RDATA     (RDATA),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .ERR       (ERR),
        .MEM_ADDR  (MEM_ADDR),
        .MEM_WDATA (MEM_WDATA),
        .MEM_READ  (MEM_READ),
        .MEM_WRITE (MEM_WRITE),
        .MEM_RDATA (MEM_RDATA),
        .MEM_ACK   (MEM_ACK)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One access. wait_c = number of wait cycles before ACK; >= TO means no ACK.
    // Ends at the sample point where DONE is seen, with requests released
    // there unless hold > 0 keeps them high for hold more cycles.
    task automatic do_txn(input bit is_wr, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wd, input logic [DW-1:0] rd,
                          input int wait_c, input int hold, input bit poke_other);
        bit ok;
        bit seen_done;
        int s_exp;
        int strobes;
        int lat;
        ok    = (wait_c >= 0) && (wait_c < TO);
        s_exp = ok ? wait_c + 1 : TO;
        @(negedge CLK);
        chk("idle_busy", BUSY, 0);
        chk("idle_done", DONE, 0);
        REQ_ADDR  = addr;
        REQ_WDATA = wd;
        MEM_RDATA = rd;
        REQ_READ  = !is_wr;
        REQ_WRITE = is_wr;
        m_addr    = addr;
        if (is_wr) m_wdata = wd;
        strobes   = 0;
        seen_done = 0;
        lat       = 0;
        for (int n = 1; n <= TO + 4 && !seen_done; n++) begin
            @(negedge CLK);
            MEM_ACK = 1'b0;
            if (DONE) begin
                seen_done = 1;
                lat       = n;
            end else begin
                chk("strobe", {MEM_READ, MEM_WRITE}, is_wr ? 2'b01 : 2'b10);
                chk("access_busy", BUSY, 1);
                chk("access_addr", MEM_ADDR, addr);
                if (is_wr) chk("access_wdata", MEM_WDATA, wd);
                MEM_ACK = (strobes == wait_c);
                strobes++;
                if (poke_other && strobes == 1) begin
                    if (is_wr) REQ_READ = 1'b1;
                    else REQ_WRITE = 1'b1;
                end
            end
        end
        chk("done_seen", seen_done, 1);
        if (!is_wr && ok) m_rdata = rd;
        chk("latency", lat, s_exp + 1);
        chk("strobe_cycles", strobes, s_exp);
        chk("done_err", ERR, !ok);
        chk("done_strobes", {MEM_READ, MEM_WRITE}, 2'b00);
        chk("done_busy", BUSY, 1);
        chk("rdata", RDATA, m_rdata);
        chk("held_addr", MEM_ADDR, m_addr);
        chk("held_wdata", MEM_WDATA, m_wdata);
        $display("txn %s addr=%h wait=%0d lat=%0d err=%0b rdata=%h",
                 is_wr ? "WR" : "RD", addr, wait_c, lat, ERR, RDATA);
        for (int h = 0; h < hold; h++) begin
            @(negedge CLK);
            chk("hold_busy", BUSY, 0);
            chk("hold_strobes", {MEM_READ, MEM_WRITE, DONE}, 3'b000);
        end
        REQ_READ  = 1'b0;
        REQ_WRITE = 1'b0;
    endtask

    // Both requests rise together: error completion without any memory strobe.
    task automatic do_illegal(input logic [AW-1:0] addr);
        @(negedge CLK);
        REQ_ADDR  = addr;
        REQ_READ  = 1'b1;
        REQ_WRITE = 1'b1;
        @(negedge CLK);
        chk("ill_done_err", {DONE, ERR, BUSY}, 3'b111);
        chk("ill_strobes", {MEM_READ, MEM_WRITE}, 2'b00);
        chk("ill_addr", MEM_ADDR, m_addr);
        $display("txn ILLEGAL addr=%h done=%0b err=%0b", addr, DONE, ERR);
        REQ_READ  = 1'b0;
        REQ_WRITE = 1'b0;
        @(negedge CLK);
        chk("ill_idle", {BUSY, DONE, ERR}, 3'b000);
    endtask

    initial begin
        // Reset state.
        #12;
        chk("reset_outs", {BUSY, DONE, ERR, MEM_READ, MEM_WRITE}, 5'b0);
        chk("reset_data", {RDATA, MEM_ADDR, MEM_WDATA}, '0);
        @(negedge CLK);
        RST = 1'b1;

        // 1: read, three wait cycles.
        do_txn(1'b0, 26'h0000100, 32'h0, 32'hDEADBEEF, 3, 2, 1'b0);
        // 2: write at top address, zero wait, request held ten more cycles.
        do_txn(1'b1, 26'h3FFFFFF, 32'h12345678, 32'h0, 0, 10, 1'b0);
        // 3: read timeout, then ACK on the last permitted edge.
        do_txn(1'b0, 26'h0000200, 32'h0, 32'hCAFEF00D, TO + 5, 0, 1'b0);
        do_txn(1'b0, 26'h0000204, 32'h0, 32'hA5A5A5A5, TO - 1, 0, 1'b0);
        // 4: illegal simultaneous request.
        do_illegal(26'h0000300);

        // 5: reset while an access is waiting; request stays high through release.
        @(negedge CLK);
        REQ_ADDR  = 26'h0000400;
        MEM_RDATA = 32'h0BADC0DE;
        REQ_READ  = 1'b1;
        repeat (2) @(negedge CLK);
        chk("pre_reset_read", MEM_READ, 1);
        #2 RST = 1'b0;
        #1;
        chk("async_outs", {BUSY, DONE, ERR, MEM_READ, MEM_WRITE}, 5'b0);
        chk("async_data", {RDATA, MEM_ADDR, MEM_WDATA}, '0);
        $display("txn RESET mid-access busy=%0b done=%0b", BUSY, DONE);
        m_addr = '0; m_wdata = '0; m_rdata = '0;
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        chk("restart_read", {MEM_READ, BUSY}, 2'b11);
        chk("restart_addr", MEM_ADDR, 26'h0000400);
        m_addr  = 26'h0000400;
        MEM_ACK = 1'b1;
        @(negedge CLK);
        MEM_ACK = 1'b0;
        m_rdata = 32'h0BADC0DE;
        chk("restart_done", {DONE, ERR}, 2'b10);
        chk("restart_rdata", RDATA, m_rdata);
        $display("txn RD after reset addr=%h rdata=%h", MEM_ADDR, RDATA);
        REQ_READ = 1'b0;

        // 6: back-to-back read then write (BUSY low exactly one cycle between).
        do_txn(1'b0, 26'h0000500, 32'h0, 32'h11112222, 1, 0, 1'b0);
        do_txn(1'b1, 26'h0000504, 32'h33334444, 32'h0, 2, 0, 1'b0);

        // Random accesses, including timeouts and ignored request toggles in ACCESS.
        for (int t = 0; t < 40; t++) begin
            do_txn(1'($urandom_range(0, 1)), AW'($urandom), $urandom, $urandom,
                   int'($urandom_range(0, TO + 3)), int'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)));
        end

        @(negedge CLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global guard so a stuck design still terminates.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
